input_loader_ctrl: RTL and testbench
====================================

// Module: input_loader_ctrl
// PURPOSE
//  Front-end controller for the multiprecision MLP accelerator. Receives pixel bytes over a
//  valid/ready stream and packs them into 16-bit input-buffer words (8-bit or dual 4-bit split).
//  After loading, pulses the accelerator start; then collects one or two inference results and
//  reports them with a done pulse. Owns input-buffer write port; accelerator owns read port.
// PARAMETERS
//  NUM_PIX  100    words written per job (addr 0..NUM_PIX-1), must be <=128
//  TIMEOUT  1023   max cycles in WAIT before error abort (10-bit counter)
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   async active-low reset
//  go          in   1   1-cycle job request; sampled only in IDLE
//  cfg_split   in   1   0: one 8-bit image; 1: two 4-bit images per beat; sampled with go
//  s_valid     in   1   pixel beat valid
//  s_ready     out  1   loader ready (high only in LOAD)
//  s_data      in   8   split=0: pixel; split=1: [3:0] image A, [7:4] image B
//  buf_we      out  1   input-buffer write enable
//  buf_addr    out  7   input-buffer write address
//  buf_wdata   out  16  split=0: {8'h00,s_data}; split=1: {4'h0,s_data[7:4],4'h0,s_data[3:0]}
//  acc_start   out  1   accelerator start, 1-cycle pulse
//  acc_split   out  1   accelerator split, held = latched cfg_split from go until next go
//  acc_valid   in   1   accelerator result strobe
//  acc_result  in   4   accelerator class index
//  res_valid   out  1   1-cycle done pulse
//  res_a       out  4   image A class (image only, if split=0)
//  res_b       out  4   image B class; 4'h0 when split=0
//  res_err     out  1   valid with res_valid: 1 = timeout abort
//  busy        out  1   high in any state except IDLE
// BEHAVIOUR
//  Reset (async): state IDLE; all outputs 0; counters 0; latched split 0. Reset mid-job aborts
//   with no res_valid; buffer contents undefined.
//  FSM: IDLE -> LOAD (go) -> FLUSH (last beat) -> START -> WAIT -> DONE -> IDLE.
//  IDLE: s_ready=0. go=1 latches cfg_split, clears pix_cnt, res_a/b, res_err; next LOAD.
//  LOAD: s_ready=1 (combinational from state). Handshake = s_valid & s_ready.
//   Registered write: handshake in cycle t -> buf_we=1, buf_addr=pix_cnt, buf_wdata packed
//   in cycle t+1; pix_cnt++. s_valid gaps allowed: buf_we=0 on those cycles.
//   Handshake with pix_cnt==NUM_PIX-1 -> FLUSH (last write visible in FLUSH).
//  FLUSH: s_ready=0; 1 cycle; -> START.
//  START: acc_start=1 exactly this cycle; -> WAIT; clear res_cnt, wait counter.
//  WAIT: each acc_valid: res_cnt==0 -> res_a<=acc_result; res_cnt==1 -> res_b<=acc_result.
//   Expected strobes: 1 (split=0) or 2 (split=1). Last expected strobe -> DONE.
//   Wait counter increments every WAIT cycle; reaching TIMEOUT -> res_err<=1, -> DONE.
//   acc_valid and timeout in same cycle: strobe wins if it is the last expected (res_err=0).
//  DONE: res_valid=1 for 1 cycle; -> IDLE. res_a/res_b/res_err hold until next go.
//  acc_valid outside WAIT: ignored. go outside IDLE: ignored (no queueing).
//  Latency: last beat handshake to acc_start = 2 cycles.
//  busy: 1 in LOAD/FLUSH/START/WAIT/DONE.
// TESTING
//  1 split=0, beats 0..99 back-to-back -> buf writes addr k data 16'h00kk; acc_start 2 cyc after
//    beat 99; acc_valid result 7 -> res_valid next DONE cycle, res_a=7, res_b=0, res_err=0.
//  2 split=1, beat 8'hA5 at idx 3 -> buf_addr 3 data 16'h0A05; acc_split=1; strobes 4 then 9
//    -> res_a=4, res_b=9, one res_valid after second strobe only.
//  3 Random s_valid gaps (50%) -> exactly 100 writes, contiguous addrs, no dup/skip.
//  4 go pulses during LOAD and WAIT; acc_valid during LOAD -> ignored, results unaffected.
//  5 No acc_valid after start -> res_valid with res_err=1 after TIMEOUT WAIT cycles; busy drops.
//  6 rst_n low at beat 50 -> all outputs 0 immediately; new go restarts at addr 0.

Source files
------------

// File: rtl/input_loader_ctrl.sv
// input_loader_ctrl: packs streamed pixel bytes into 16-bit input-buffer words, starts the
// MLP accelerator, then gathers one or two class results and reports them with a done pulse.
module input_loader_ctrl #(
    parameter int NUM_PIX = 100,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic        cfg_split,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    output logic        buf_we,
    output logic [6:0]  buf_addr,
    output logic [15:0] buf_wdata,
    output logic        acc_start,
    output logic        acc_split,
    input  logic        acc_valid,
    input  logic [3:0]  acc_result,
    output logic        res_valid,
    output logic [3:0]  res_a,
    output logic [3:0]  res_b,
    output logic        res_err,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, START, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [6:0]  pix_cnt_q, pix_cnt_d;
    logic [9:0]  wait_cnt_q, wait_cnt_d;
    logic        res_cnt_q, res_cnt_d;
    logic        split_q, split_d;
    logic        buf_we_q, buf_we_d;
    logic [6:0]  buf_addr_q, buf_addr_d;
    logic [15:0] buf_wdata_q, buf_wdata_d;
    logic        acc_start_q, acc_start_d;
    logic        res_valid_q, res_valid_d;
    logic [3:0]  res_a_q, res_a_d;
    logic [3:0]  res_b_q, res_b_d;
    logic        res_err_q, res_err_d;
    logic        hs;
    logic        last_res;
    logic        timed_out;

    assign s_ready   = (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign hs        = s_valid && s_ready;
    // Split jobs expect a second strobe, so the last one arrives when res_cnt equals split.
    assign last_res  = acc_valid && (res_cnt_q == split_q);
    assign timed_out = (wait_cnt_q == 10'(TIMEOUT - 1));

    assign buf_we    = buf_we_q;
    assign buf_addr  = buf_addr_q;
    assign buf_wdata = buf_wdata_q;
    assign acc_start = acc_start_q;
    assign acc_split = split_q;
    assign res_valid = res_valid_q;
    assign res_a     = res_a_q;
    assign res_b     = res_b_q;
    assign res_err   = res_err_q;

    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        res_cnt_d   = res_cnt_q;
        split_d     = split_q;
        buf_we_d    = 1'b0;
        buf_addr_d  = buf_addr_q;
        buf_wdata_d = buf_wdata_q;
        acc_start_d = 1'b0;
        res_valid_d = 1'b0;
        res_a_d     = res_a_q;
        res_b_d     = res_b_q;
        res_err_d   = res_err_q;
        case (state_q)
            IDLE: if (go) begin
                state_d   = LOAD;
                split_d   = cfg_split;
                pix_cnt_d = 7'd0;
                res_a_d   = 4'h0;
                res_b_d   = 4'h0;
                res_err_d = 1'b0;
            end
            LOAD: if (hs) begin
                buf_we_d    = 1'b1;
                buf_addr_d  = pix_cnt_q;
                buf_wdata_d = split_q ? {4'h0, s_data[7:4], 4'h0, s_data[3:0]} : {8'h00, s_data};
                pix_cnt_d   = pix_cnt_q + 7'd1;
                if (pix_cnt_q == 7'(NUM_PIX - 1)) state_d = FLUSH;
            end
            FLUSH: begin
                state_d     = START;
                acc_start_d = 1'b1;
            end
            START: begin
                state_d    = WAIT;
                res_cnt_d  = 1'b0;
                wait_cnt_d = 10'd0;
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q + 10'd1;
                if (acc_valid) begin
                    res_a_d   = res_cnt_q ? res_a_q : acc_result;
                    res_b_d   = res_cnt_q ? acc_result : res_b_q;
                    res_cnt_d = 1'b1;
                end
                // A final strobe landing on the timeout cycle still counts as success.
                if (last_res || timed_out) begin
                    state_d     = DONE;
                    res_valid_d = 1'b1;
                    res_err_d   = !last_res;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pix_cnt_q   <= 7'd0;
            wait_cnt_q  <= 10'd0;
            res_cnt_q   <= 1'b0;
            split_q     <= 1'b0;
            buf_we_q    <= 1'b0;
            buf_addr_q  <= 7'd0;
            buf_wdata_q <= 16'h0000;
            acc_start_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_a_q     <= 4'h0;
            res_b_q     <= 4'h0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            res_cnt_q   <= res_cnt_d;
            split_q     <= split_d;
            buf_we_q    <= buf_we_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
            acc_start_q <= acc_start_d;
            res_valid_q <= res_valid_d;
            res_a_q     <= res_a_d;
            res_b_q     <= res_b_d;
            res_err_q   <= res_err_d;
        end
    end
endmodule

// File: tb/tb_input_loader_ctrl.sv
// tb_input_loader_ctrl: directed checks of loading, packing, result collection, timeout and reset.
module tb_input_loader_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic        cfg_split = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic        buf_we;
    logic [6:0]  buf_addr;
    logic [15:0] buf_wdata;
    logic        acc_start;
    logic        acc_split;
    logic        acc_valid = 1'b0;
    logic [3:0]  acc_result = 4'h0;
    logic        res_valid;
    logic [3:0]  res_a;
    logic [3:0]  res_b;
    logic        res_err;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    input_loader_ctrl dut (
        .clk(clk), .rst_n(rst_n), .go(go), .cfg_split(cfg_split),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .acc_start(acc_start), .acc_split(acc_split),
        .acc_valid(acc_valid), .acc_result(acc_result),
        .res_valid(res_valid), .res_a(res_a), .res_b(res_b), .res_err(res_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pack(input logic [7:0] d, input logic split);
        return split ? {4'h0, d[7:4], 4'h0, d[3:0]} : {8'h00, d};
    endfunction

    task automatic start_job(input logic split);
        go = 1'b1;
        cfg_split = split;
        tick;
        go = 1'b0;
        cfg_split = ~split;
        chk("job_busy", 16'(busy), 16'd1);
        chk("job_ready", 16'(s_ready), 16'd1);
        chk("job_split", 16'(acc_split), 16'(split));
    endtask

    task automatic load_beat(input logic [7:0] d, input logic [6:0] a, input logic split);
        s_valid = 1'b1;
        s_data = d;
        tick;
        chk("wr_we", 16'(buf_we), 16'd1);
        chk("wr_addr", 16'(buf_addr), 16'(a));
        chk("wr_data", buf_wdata, pack(d, split));
    endtask

    initial begin
        logic [7:0] d;
        int n;
        int cyc;
        int v;
        tick;
        tick;
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_ready", 16'(s_ready), 16'd0);
        chk("rst_we", 16'(buf_we), 16'd0);
        chk("rst_start", 16'(acc_start), 16'd0);
        chk("rst_res", {res_valid, res_err, acc_split, res_a, res_b}, 16'd0);
        rst_n = 1'b1;
        tick;
        chk("idle_ready", 16'(s_ready), 16'd0);

        // 1: unsplit job, back-to-back beats, one result
        start_job(1'b0);
        for (int k = 0; k < 100; k++) load_beat(8'(k), 7'(k), 1'b0);
        s_valid = 1'b0;
        chk("t1_flush_ready", 16'(s_ready), 16'd0);
        chk("t1_flush_start", 16'(acc_start), 16'd0);
        tick;
        chk("t1_start", 16'(acc_start), 16'd1);
        chk("t1_start_we", 16'(buf_we), 16'd0);
        tick;
        chk("t1_start_pulse", 16'(acc_start), 16'd0);
        acc_valid = 1'b1;
        acc_result = 4'd7;
        tick;
        acc_valid = 1'b0;
        chk("t1_done", 16'(res_valid), 16'd1);
        chk("t1_res_a", 16'(res_a), 16'd7);
        chk("t1_res_b", 16'(res_b), 16'd0);
        chk("t1_err", 16'(res_err), 16'd0);
        tick;
        chk("t1_pulse", 16'(res_valid), 16'd0);
        chk("t1_idle", 16'(busy), 16'd0);
        chk("t1_hold_a", 16'(res_a), 16'd7);

        // 2: split job, two results, done only after the second
        start_job(1'b1);
        chk("t2_clear_a", 16'(res_a), 16'd0);
        for (int k = 0; k < 100; k++) begin
            d = (k == 3) ? 8'hA5 : 8'(k * 3);
            load_beat(d, 7'(k), 1'b1);
            if (k == 3) chk("t2_pack", buf_wdata, 16'h0A05);
        end
        s_valid = 1'b0;
        tick;
        chk("t2_start", 16'(acc_start), 16'd1);
        tick;
        acc_valid = 1'b1;
        acc_result = 4'd4;
        tick;
        acc_valid = 1'b0;
        chk("t2_no_early_done", 16'(res_valid), 16'd0);
        chk("t2_res_a", 16'(res_a), 16'd4);
        tick;
        chk("t2_still_wait", 16'(res_valid), 16'd0);
        acc_valid = 1'b1;
        acc_result = 4'd9;
        tick;
        acc_valid = 1'b0;
        chk("t2_done", 16'(res_valid), 16'd1);
        chk("t2_res", {8'h00, res_a, res_b}, 16'h0049);
        chk("t2_err", 16'(res_err), 16'd0);
        chk("t2_split", 16'(acc_split), 16'd1);
        tick;
        chk("t2_pulse", 16'(res_valid), 16'd0);

        // 3+4: random s_valid gaps with stray go and acc_valid during LOAD
        start_job(1'b0);
        n = 0;
        cyc = 0;
        while (n < 100 && cyc < 2000) begin
            v = $urandom_range(0, 1);
            go = (cyc % 7 == 3);
            acc_valid = (cyc % 5 == 1);
            acc_result = 4'hF;
            s_valid = v[0];
            s_data = 8'(n + 17);
            tick;
            if (v != 0) begin
                chk("t3_we", 16'(buf_we), 16'd1);
                chk("t3_addr", 16'(buf_addr), 16'(n));
                chk("t3_data", buf_wdata, {8'h00, 8'(n + 17)});
                n++;
            end else chk("t3_gap_we", 16'(buf_we), 16'd0);
            cyc++;
        end
        go = 1'b0;
        acc_valid = 1'b0;
        s_valid = 1'b0;
        chk("t3_count", 16'(n), 16'd100);
        chk("t3_flush", 16'(s_ready), 16'd0);
        tick;
        chk("t3_start", 16'(acc_start), 16'd1);
        tick;
        go = 1'b1;
        tick;
        go = 1'b0;
        chk("t4_go_wait", 16'(busy), 16'd1);
        chk("t4_no_done", 16'(res_valid), 16'd0);
        acc_valid = 1'b1;
        acc_result = 4'd3;
        tick;
        acc_result = 4'd5;
        chk("t4_done", 16'(res_valid), 16'd1);
        chk("t4_res", {8'h00, res_a, res_b}, 16'h0030);
        tick;
        chk("t4_idle", 16'(busy), 16'd0);
        tick;
        acc_valid = 1'b0;
        chk("t4_ignore_idle", 16'(res_a), 16'd3);
        chk("t4_no_pulse", 16'(res_valid), 16'd0);

        // 5: no result strobe -> timeout abort
        start_job(1'b0);
        for (int k = 0; k < 100; k++) load_beat(8'(255 - k), 7'(k), 1'b0);
        s_valid = 1'b0;
        tick;
        chk("t5_start", 16'(acc_start), 16'd1);
        n = 0;
        do begin
            tick;
            n++;
        end while (!res_valid && n < 1100);
        chk("t5_latency", 16'(n), 16'd1024);
        chk("t5_err", 16'(res_err), 16'd1);
        chk("t5_res", {8'h00, res_a, res_b}, 16'h0000);
        tick;
        chk("t5_idle", 16'(busy), 16'd0);
        chk("t5_err_hold", 16'(res_err), 16'd1);

        // 6: asynchronous reset mid-load, then a clean restart
        start_job(1'b1);
        for (int k = 0; k < 50; k++) load_beat(8'(k + 1), 7'(k), 1'b1);
        s_valid = 1'b1;
        s_data = 8'd50;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 16'(busy), 16'd0);
        chk("t6_ready", 16'(s_ready), 16'd0);
        chk("t6_we", 16'(buf_we), 16'd0);
        chk("t6_addr", 16'(buf_addr), 16'd0);
        chk("t6_data", buf_wdata, 16'h0000);
        chk("t6_split", 16'(acc_split), 16'd0);
        chk("t6_res", {res_valid, res_err, acc_start, res_a, res_b}, 16'd0);
        s_valid = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        chk("t6_idle", 16'(busy), 16'd0);
        start_job(1'b0);
        load_beat(8'h33, 7'd0, 1'b0);
        s_valid = 1'b0;
        chk("t6_restart_addr", 16'(buf_addr), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
